// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the byte-serial memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int RamAddrW = 18;

    // Size code 3 is treated as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] code);
        case (code)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module mem_port_arbiter_rr #(
    parameter int NCH = 2,
    parameter int PW  = 1
) (
    input  logic [NCH-1:0] req_i,
    input  logic [PW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [PW-1:0]  idx_o,
    output logic           valid_o
);

    int cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int off = 0; off < NCH; off++) begin
            cand = int'(ptr_i) + off;
            if (cand >= NCH) cand = cand - NCH;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel round-robin arbiter onto a single byte-wide synchronous RAM port.
// Transfers are 1/2/4 bytes little-endian; channel 0 reads can be flushed.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NCH = 2,
    parameter int AW  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rdy_i,
    input  logic [NCH-1:0]    req_i,
    input  logic [NCH-1:0]    we_i,
    input  logic [2*NCH-1:0]  size_i,
    input  logic [AW*NCH-1:0] addr_i,
    input  logic [32*NCH-1:0] wdata_i,
    input  logic              flush0_i,
    output logic [NCH-1:0]    done_o,
    output logic [31:0]       rdata_o,
    input  logic [7:0]        mem_din_i,
    output logic [7:0]        mem_dout_o,
    output logic [AW-1:0]     mem_a_o,
    output logic              mem_wr_o,
    output state_e            state_o
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    state_e         state_q, state_d;
    logic [2:0]     k_q, k_d, nb_q, nb_d;
    logic [PW-1:0]  ptr_q, ptr_d, ch_q, ch_d;
    logic [AW-1:0]  addr_q, addr_d, mem_a_q, mem_a_d;
    logic [31:0]    wdata_q, wdata_d, buf_q, buf_d, rdata_q, rdata_d;
    logic [NCH-1:0] done_q, done_d;
    logic [7:0]     mem_dout_q, mem_dout_d;
    logic           mem_wr_q, mem_wr_d;

    logic [NCH-1:0] elig, arb_gnt;
    logic [PW-1:0]  arb_idx;
    logic           arb_valid, sel_we, flush_hit;
    logic [1:0]     sel_size;
    logic [AW-1:0]  sel_addr, next_a;
    logic [31:0]    sel_wdata;
    logic [2:0]     k_inc;

    // A channel whose done is showing cannot be re-granted in the same cycle.
    assign elig = req_i & ~done_q & ~{{(NCH-1){1'b0}}, flush0_i};

    mem_port_arbiter_rr #(.NCH(NCH), .PW(PW)) u_rr (
        .req_i  (elig),
        .ptr_i  (ptr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .valid_o(arb_valid)
    );

    assign sel_we    = |(arb_gnt & we_i);
    assign sel_size  = size_i[2*arb_idx +: 2];
    assign sel_addr  = addr_i[AW*arb_idx +: AW];
    assign sel_wdata = wdata_i[32*arb_idx +: 32];
    assign flush_hit = flush0_i && (ch_q == '0);
    assign k_inc     = k_q + 3'd1;
    assign next_a    = addr_q + AW'(k_inc);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            nb_q       <= '0;
            ptr_q      <= '0;
            ch_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            rdata_q    <= '0;
            done_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            nb_q       <= nb_d;
            ptr_q      <= ptr_d;
            ch_q       <= ch_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        if (rdy_i) begin
            unique case (state_q)
                ST_IDLE:  if (arb_valid) state_d = sel_we ? ST_WRITE : ST_READ;
                ST_READ:  if (flush_hit || (k_q == nb_q)) state_d = ST_IDLE;
                ST_WRITE: if (k_q == nb_q - 3'd1) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin : outputs
        k_d        = k_q;
        nb_d       = nb_q;
        ptr_d      = ptr_q;
        ch_d       = ch_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        rdata_d    = rdata_q;
        done_d     = done_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if (rdy_i) begin
            done_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        nb_d       = size_bytes(sel_size);
                        k_d        = '0;
                        ch_d       = arb_idx;
                        addr_d     = sel_addr;
                        wdata_d    = sel_wdata;
                        buf_d      = '0;
                        mem_a_d    = sel_addr;
                        mem_dout_d = sel_wdata[7:0];
                        mem_wr_d   = sel_we;
                        ptr_d      = (int'(arb_idx) == NCH - 1) ? '0 : arb_idx + PW'(1);
                    end
                end
                ST_READ: begin
                    // Bytes gather in buf_q so a flushed read leaves rdata untouched.
                    if (flush_hit) begin
                        k_d = '0;
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (int'(k_q) == b + 1) buf_d[8*b +: 8] = mem_din_i;
                        end
                        if (k_q == nb_q) begin
                            rdata_d      = buf_d;
                            done_d[ch_q] = 1'b1;
                            k_d          = '0;
                        end else begin
                            k_d = k_inc;
                            if (k_inc < nb_q) mem_a_d = next_a;
                        end
                    end
                end
                ST_WRITE: begin
                    if (k_q == nb_q - 3'd1) begin
                        done_d[ch_q] = 1'b1;
                        mem_wr_d     = 1'b0;
                        k_d          = '0;
                    end else begin
                        k_d     = k_inc;
                        mem_a_d = next_a;
                        for (int b = 0; b < 4; b++) begin
                            if (int'(k_inc) == b) mem_dout_d = wdata_q[8*b +: 8];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pausing masks the strobes without disturbing the registered values.
    assign done_o     = done_q & {NCH{rdy_i}};
    assign mem_wr_o   = mem_wr_q & rdy_i;
    assign rdata_o    = rdata_q;
    assign mem_a_o    = mem_a_q;
    assign mem_dout_o = mem_dout_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (NCH=3) against a synchronous byte RAM model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int NCH = 3;
    localparam int AW  = 32;

    logic              clk = 1'b0;
    logic              rst_n, rdy, flush0;
    logic [NCH-1:0]    req, we, done;
    logic [2*NCH-1:0]  size;
    logic [AW*NCH-1:0] addr;
    logic [32*NCH-1:0] wdata;
    logic [31:0]       rdata;
    logic [7:0]        mem_din, mem_dout;
    logic [AW-1:0]     mem_a;
    logic              mem_wr;
    state_e            state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  ram [0:(1<<RamAddrW)-1];

    mem_port_arbiter #(.NCH(NCH), .AW(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy), .req_i(req), .we_i(we),
        .size_i(size), .addr_i(addr), .wdata_i(wdata), .flush0_i(flush0),
        .done_o(done), .rdata_o(rdata), .mem_din_i(mem_din), .mem_dout_o(mem_dout),
        .mem_a_o(mem_a), .mem_wr_o(mem_wr), .state_o(state)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: preset while in reset, otherwise advances only on rdy-high edges.
    always @(posedge clk) begin
        if (!rst_n) begin
            ram[18'h000] <= 8'hA0; ram[18'h001] <= 8'hA1;
            ram[18'h002] <= 8'hA2; ram[18'h003] <= 8'hA3;
            ram[18'h100] <= 8'h11; ram[18'h101] <= 8'h22;
            ram[18'h102] <= 8'h33; ram[18'h103] <= 8'h44;
            ram[18'h200] <= 8'h5A;
        end else if (rdy) begin
            if (mem_wr) ram[mem_a[RamAddrW-1:0]] <= mem_dout;
            mem_din <= ram[mem_a[RamAddrW-1:0]];
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        we[ch]            = w;
        size[2*ch +: 2]   = sz;
        addr[AW*ch +: AW] = a;
        wdata[32*ch +: 32] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== ST_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want %0d", state, ST_IDLE); end
        n_cmp++; if (done !== 3'b000) begin n_bad++; $display("FAIL rst_done: got %b want 000", done); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        n_cmp++; if (mem_a !== 32'h0) begin n_bad++; $display("FAIL rst_mem_a: got %h want 0", mem_a); end
        n_cmp++; if (mem_wr !== 1'b0 || mem_dout !== 8'h00) begin n_bad++; $display("FAIL rst_mem_wr_dout: got %b/%h want 0/00", mem_wr, mem_dout); end
        step();
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (state !== ST_IDLE) begin n_bad++; $display("FAIL idle_no_req: got %0d want %0d", state, ST_IDLE); end
    endtask

    task automatic test_single_read();
        int done_cyc = 0;
        set_ch(1, 1'b0, SZ_WORD, 32'h100, 32'h0);
        req = 3'b010;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            step();
            if (cyc <= 4) begin
                n_cmp++;
                if (mem_a !== 32'h100 + cyc - 1 || mem_wr !== 1'b0) begin
                    n_bad++; $display("FAIL read_addr cyc%0d: got %h/%b want %h/0", cyc, mem_a, mem_wr, 32'h100 + cyc - 1);
                end
            end
            if (done !== 3'b000 && done_cyc == 0) begin
                done_cyc = cyc;
                req = 3'b000;
                n_cmp++;
                if (done !== 3'b010 || rdata !== 32'h44332211) begin
                    n_bad++; $display("FAIL read_data: got done=%b rdata=%h want 010/44332211", done, rdata);
                end
            end
        end
        n_cmp++; if (done_cyc != 6) begin n_bad++; $display("FAIL read_latency: got %0d want 6", done_cyc); end
    endtask

    task automatic test_write();
        int wr_cnt = 0;
        set_ch(1, 1'b1, SZ_HALF, 32'h1FE, 32'hAABBCCDD);
        req = 3'b010;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            step();
            if (mem_wr === 1'b1) wr_cnt++;
            if (cyc == 1) begin
                n_cmp++;
                if (mem_wr !== 1'b1 || mem_a !== 32'h1FE || mem_dout !== 8'hDD) begin
                    n_bad++; $display("FAIL write_b0: got %b/%h/%h want 1/1fe/dd", mem_wr, mem_a, mem_dout);
                end
            end
            if (cyc == 2) begin
                n_cmp++;
                if (mem_wr !== 1'b1 || mem_a !== 32'h1FF || mem_dout !== 8'hCC) begin
                    n_bad++; $display("FAIL write_b1: got %b/%h/%h want 1/1ff/cc", mem_wr, mem_a, mem_dout);
                end
            end
            if (cyc == 3) begin
                n_cmp++;
                if (done !== 3'b010 || mem_wr !== 1'b0) begin
                    n_bad++; $display("FAIL write_done: got done=%b wr=%b want 010/0", done, mem_wr);
                end
                req = 3'b000;
            end
        end
        n_cmp++; if (wr_cnt != 2) begin n_bad++; $display("FAIL write_cycles: got %0d want 2", wr_cnt); end
        n_cmp++;
        if (ram[18'h1FE] !== 8'hDD || ram[18'h1FF] !== 8'hCC || ram[18'h200] !== 8'h5A) begin
            n_bad++; $display("FAIL write_ram: got %h %h %h want dd cc 5a", ram[18'h1FE], ram[18'h1FF], ram[18'h200]);
        end
    endtask

    task automatic test_flush();
        int done1_cyc = 0;
        int n_done0 = 0;
        set_ch(0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        set_ch(1, 1'b0, SZ_BYTE, 32'h100, 32'h0);
        req = 3'b011;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            step();
            if (done[0] !== 1'b0) n_done0++;
            if (cyc == 3) flush0 = 1'b1;
            if (cyc == 4) begin
                n_cmp++;
                if (state !== ST_IDLE || rdata !== 32'h44332211) begin
                    n_bad++; $display("FAIL flush_idle: got state=%0d rdata=%h want 0/44332211", state, rdata);
                end
                flush0 = 1'b0;
                req[0] = 1'b0;
            end
            if (cyc == 5) begin
                n_cmp++;
                if (state !== ST_READ || mem_a !== 32'h100) begin
                    n_bad++; $display("FAIL flush_regrant: got state=%0d mem_a=%h want 1/100", state, mem_a);
                end
            end
            if (done[1] === 1'b1 && done1_cyc == 0) begin
                done1_cyc = cyc;
                req[1] = 1'b0;
                n_cmp++;
                if (rdata !== 32'h00000011) begin n_bad++; $display("FAIL flush_ch1_data: got %h want 00000011", rdata); end
            end
        end
        n_cmp++; if (n_done0 != 0) begin n_bad++; $display("FAIL flush_no_done0: got %0d pulses want 0", n_done0); end
        n_cmp++; if (done1_cyc != 7) begin n_bad++; $display("FAIL flush_ch1_latency: got %0d want 7", done1_cyc); end
    endtask

    task automatic test_pause();
        int done_cyc = 0;
        set_ch(1, 1'b0, SZ_WORD, 32'h100, 32'h0);
        req = 3'b010;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            step();
            if (cyc == 2) rdy = 1'b0;
            if (cyc >= 3 && cyc <= 5) begin
                n_cmp++;
                if (mem_a !== 32'h101 || mem_wr !== 1'b0 || done !== 3'b000) begin
                    n_bad++; $display("FAIL pause_hold cyc%0d: got %h/%b/%b want 101/0/000", cyc, mem_a, mem_wr, done);
                end
                if (cyc == 5) rdy = 1'b1;
            end
            if (done !== 3'b000 && done_cyc == 0) begin
                done_cyc = cyc;
                req = 3'b000;
                n_cmp++;
                if (done !== 3'b010 || rdata !== 32'h44332211) begin
                    n_bad++; $display("FAIL pause_data: got done=%b rdata=%h want 010/44332211", done, rdata);
                end
            end
        end
        n_cmp++; if (done_cyc != 9) begin n_bad++; $display("FAIL pause_latency: got %0d want 9", done_cyc); end
    endtask

    task automatic test_reset_mid_write();
        int done0_cyc = 0;
        int done1_cyc = 0;
        set_ch(0, 1'b1, SZ_WORD, 32'h300, 32'h87654321);
        req = 3'b001;
        step();
        n_cmp++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h300 || mem_dout !== 8'h21) begin
            n_bad++; $display("FAIL rstw_b0: got %b/%h/%h want 1/300/21", mem_wr, mem_a, mem_dout);
        end
        step();
        n_cmp++;
        if (mem_a !== 32'h301 || mem_dout !== 8'h43) begin
            n_bad++; $display("FAIL rstw_b1: got %h/%h want 301/43", mem_a, mem_dout);
        end
        rst_n = 1'b0;
        req = 3'b000;
        #1;
        n_cmp++;
        if (state !== ST_IDLE || mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h00) begin
            n_bad++; $display("FAIL rstw_async_mem: got %0d/%b/%h/%h want 0/0/0/00", state, mem_wr, mem_a, mem_dout);
        end
        n_cmp++;
        if (done !== 3'b000 || rdata !== 32'h0) begin
            n_bad++; $display("FAIL rstw_async_data: got %b/%h want 000/0", done, rdata);
        end
        step();
        step();
        rst_n = 1'b1;
        set_ch(0, 1'b0, SZ_BYTE, 32'h102, 32'h0);
        set_ch(1, 1'b0, SZ_BYTE, 32'h101, 32'h0);
        req = 3'b011;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            step();
            if (cyc == 1) begin
                n_cmp++;
                if (mem_a !== 32'h102) begin n_bad++; $display("FAIL rstw_first_grant: got %h want 102", mem_a); end
            end
            if (done[0] === 1'b1 && done0_cyc == 0) begin
                done0_cyc = cyc;
                req[0] = 1'b0;
                n_cmp++;
                if (rdata !== 32'h33) begin n_bad++; $display("FAIL rstw_ch0_data: got %h want 33", rdata); end
            end
            if (done[1] === 1'b1 && done1_cyc == 0) begin
                done1_cyc = cyc;
                req[1] = 1'b0;
                n_cmp++;
                if (rdata !== 32'h22) begin n_bad++; $display("FAIL rstw_ch1_data: got %h want 22", rdata); end
            end
        end
        n_cmp++;
        if (done0_cyc != 3 || done1_cyc != 6) begin
            n_bad++; $display("FAIL rstw_order: got ch0@%0d ch1@%0d want 3/6", done0_cyc, done1_cyc);
        end
    endtask

    task automatic test_round_robin();
        int seen = 0;
        logic [31:0] exp_ch;
        do_reset();
        set_ch(0, 1'b0, SZ_BYTE, 32'h100, 32'h0);
        set_ch(1, 1'b0, SZ_BYTE, 32'h101, 32'h0);
        set_ch(2, 1'b0, SZ_BYTE, 32'h102, 32'h0);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(32'd0);
            exp_q.push_back(32'd1);
            exp_q.push_back(32'd2);
        end
        req = 3'b111;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            step();
            if (done !== 3'b000) begin
                seen++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rr_extra: got done=%b at cyc%0d want none", done, cyc);
                end else begin
                    exp_ch = exp_q.pop_front();
                    if (done !== 3'(1 << exp_ch) || cyc != 3 * seen || rdata !== 32'h11 * (exp_ch + 1)) begin
                        n_bad++;
                        $display("FAIL rr_grant #%0d: got done=%b cyc=%0d rdata=%h want ch%0d cyc=%0d rdata=%h",
                                 seen, done, cyc, rdata, exp_ch, 3 * seen, 32'h11 * (exp_ch + 1));
                    end
                end
            end
        end
        req = 3'b000;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rr_missing: got %0d outstanding want 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush0 = 1'b0;
        req = '0; we = '0; size = '0; addr = '0; wdata = '0;
        test_reset();
        test_single_read();
        test_write();
        test_flush();
        test_pause();
        test_reset_mid_write();
        test_round_robin();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
